// File: rtl/battle_pkg.sv
// battle_pkg: shared types and constants for the battle datapath
package battle_pkg;
  typedef enum logic [1:0] {IDLE, MULT, SCALE, DONE} calc_state_t;
  localparam logic TRAINER_PLAYER = 1'b0;
  localparam logic TRAINER_AI = 1'b1;
  localparam logic [7:0] MOVE_POWER [4] = '{8'd40, 8'd60, 8'd80, 8'd120};
  function automatic logic [7:0] move_power(input logic [1:0] idx);
    return MOVE_POWER[idx];
  endfunction
endpackage

// File: rtl/battle_datapath_mult.sv
// shift_add_mult8: 8x8->16 sequential shift-add multiplier, one multiplier bit per cycle
module shift_add_mult8 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);
  logic [15:0] mcand;
  logic [7:0]  mplier;
  logic [2:0]  cnt;
  // done marks the cycle consuming bit 7; product is final after that edge
  assign done = busy && cnt == 3'd7;
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      product <= '0;
      mcand <= '0;
      mplier <= '0;
      cnt <= '0;
    end else if (start && !busy) begin
      busy <= 1'b1;
      product <= '0;
      mcand <= {8'd0, a};
      mplier <= b;
      cnt <= '0;
    end else if (busy) begin
      product <= product + (mplier[0] ? mcand : 16'd0);
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + 3'd1;
      busy <= !done;
    end
  end
endmodule

// File: rtl/battle_datapath.sv
// battle_datapath: move/HP storage, multi-cycle damage calculation and edge-triggered damage apply
module battle_datapath
  import battle_pkg::*;
#(
  parameter int HP_W   = 8,
  parameter int MAX_HP = 200,
  parameter int P_ATK  = 40,
  parameter int P_DEF  = 20,
  parameter int AI_ATK = 36,
  parameter int AI_DEF = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ld_move,
  input  logic [1:0]      p_move_sel,
  input  logic [1:0]      ai_move_sel,
  input  logic            calc_damage,
  input  logic            active_trainer,
  input  logic            apply_damage,
  input  logic            target,
  output logic            dmg_valid,
  output logic [HP_W-1:0] damage,
  output logic [HP_W-1:0] p_hp,
  output logic [HP_W-1:0] ai_hp,
  output logic            p_hp_zero,
  output logic            ai_hp_zero
);
  localparam logic [15:0]     DMG_MAX = 16'((1 << HP_W) - 1);
  localparam logic [HP_W-1:0] HP_INIT = HP_W'(MAX_HP);
  calc_state_t state, next;
  logic [1:0]      move_q;
  logic [7:0]      def_q;
  logic            apply_q, rise, start, mult_busy, mult_done;
  logic [7:0]      mcand, mplier;
  logic [15:0]     product, raw, dmg_raw;
  logic [HP_W-1:0] dmg_sat, p_next, ai_next;
  assign start  = state == IDLE && calc_damage;
  assign mcand  = active_trainer == TRAINER_AI ? move_power(ai_move_sel) : move_power(move_q);
  assign mplier = active_trainer == TRAINER_AI ? 8'(AI_ATK) : 8'(P_ATK);
  shift_add_mult8 u_mult (
    .clk(clk), .reset(reset), .start(start), .a(mcand), .b(mplier),
    .busy(mult_busy), .done(mult_done), .product(product)
  );
  always_comb begin
    next = (state == IDLE)  ? (calc_damage ? MULT : IDLE) :
           (state == MULT)  ? (mult_done ? SCALE : MULT) :
           (state == SCALE) ? DONE :
                              (calc_damage ? DONE : IDLE);
  end
  always_ff @(posedge clk) state <= reset ? IDLE : next;
  assign dmg_valid = state == DONE;
  // minimum damage is 1, then clamp to the HP range
  assign raw     = product >> 4;
  assign dmg_raw = raw > {8'd0, def_q} ? raw - {8'd0, def_q} : 16'd1;
  assign dmg_sat = dmg_raw > DMG_MAX ? DMG_MAX[HP_W-1:0] : dmg_raw[HP_W-1:0];
  assign rise    = apply_damage && !apply_q;
  assign p_next  = (rise && target == TRAINER_PLAYER) ? (p_hp > damage ? p_hp - damage : '0) : p_hp;
  assign ai_next = (rise && target == TRAINER_AI) ? (ai_hp > damage ? ai_hp - damage : '0) : ai_hp;
  always_ff @(posedge clk) begin
    if (reset) begin
      move_q <= '0;
      def_q <= '0;
      damage <= '0;
      apply_q <= 1'b0;
      p_hp <= HP_INIT;
      ai_hp <= HP_INIT;
      p_hp_zero <= 1'b0;
      ai_hp_zero <= 1'b0;
    end else begin
      if (ld_move && state == IDLE) move_q <= p_move_sel;
      if (start) def_q <= active_trainer == TRAINER_AI ? 8'(P_DEF) : 8'(AI_DEF);
      if (state == SCALE) damage <= dmg_sat;
      apply_q <= apply_damage;
      p_hp <= p_next;
      ai_hp <= ai_next;
      p_hp_zero <= p_next == '0;
      ai_hp_zero <= ai_next == '0;
    end
  end
endmodule

// File: tb/tb_battle_datapath.sv
// tb_battle_datapath: directed checks of damage calc, apply, saturation and reset behaviour
module tb_battle_datapath;
  logic clk = 1'b0;
  logic reset, ld_move, calc_damage, active_trainer, apply_damage, target;
  logic [1:0] p_move_sel, ai_move_sel;
  logic dmg_valid, p_hp_zero, ai_hp_zero, m_valid, m_pz, m_az;
  logic [7:0] damage, p_hp, ai_hp, m_damage, m_php, m_aihp;
  int n_cmp = 0, n_bad = 0, n;
  always #5 clk = ~clk;
  battle_datapath u_dut (
    .clk(clk), .reset(reset), .ld_move(ld_move), .p_move_sel(p_move_sel),
    .ai_move_sel(ai_move_sel), .calc_damage(calc_damage), .active_trainer(active_trainer),
    .apply_damage(apply_damage), .target(target), .dmg_valid(dmg_valid), .damage(damage),
    .p_hp(p_hp), .ai_hp(ai_hp), .p_hp_zero(p_hp_zero), .ai_hp_zero(ai_hp_zero)
  );
  battle_datapath #(.P_ATK(4)) u_min (
    .clk(clk), .reset(reset), .ld_move(ld_move), .p_move_sel(p_move_sel),
    .ai_move_sel(ai_move_sel), .calc_damage(calc_damage), .active_trainer(active_trainer),
    .apply_damage(apply_damage), .target(target), .dmg_valid(m_valid), .damage(m_damage),
    .p_hp(m_php), .ai_hp(m_aihp), .p_hp_zero(m_pz), .ai_hp_zero(m_az)
  );
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load_move(input logic [1:0] sel);
    p_move_sel = sel;
    ld_move = 1'b1;
    tick();
    ld_move = 1'b0;
  endtask
  // raise calc, count edges until dmg_valid, hold, then release
  task automatic do_calc(input logic at, input logic [1:0] ai_sel, input int exp_dmg);
    active_trainer = at;
    ai_move_sel = ai_sel;
    calc_damage = 1'b1;
    tick();
    n = 0;
    while (!dmg_valid && n < 20) begin
      tick();
      n++;
    end
    chk("latency", n, 9);
    chk("damage", damage, exp_dmg);
    repeat (2) tick();
    chk("dv_hold", dmg_valid, 1);
    calc_damage = 1'b0;
    tick();
    chk("dv_clear", dmg_valid, 0);
  endtask
  task automatic do_apply(input logic tgt);
    target = tgt;
    apply_damage = 1'b1;
    repeat (5) tick();
    apply_damage = 1'b0;
    tick();
  endtask
  initial begin
    reset = 1'b1; ld_move = 0; calc_damage = 0; active_trainer = 0;
    apply_damage = 0; target = 0; p_move_sel = 0; ai_move_sel = 0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("rst_p_hp", p_hp, 200);
    chk("rst_ai_hp", ai_hp, 200);
    chk("rst_pz", p_hp_zero, 0);
    chk("rst_az", ai_hp_zero, 0);
    chk("rst_dv", dmg_valid, 0);
    chk("rst_damage", damage, 0);
    // player move 1: 60*40>>4=150, -16 = 134; u_min: 60*4>>4=15 <= 16 -> 1
    load_move(2'd1);
    do_calc(1'b0, 2'd0, 134);
    chk("min_dmg_move1", m_damage, 1);
    do_apply(1'b1);
    chk("ai_hp_once", ai_hp, 66);
    chk("p_hp_untouched", p_hp, 200);
    // AI move 0: 40*36>>4=90, -20 = 70
    do_calc(1'b1, 2'd0, 70);
    do_apply(1'b0);
    chk("p_hp_after_ai", p_hp, 130);
    chk("ai_hp_after_ai", ai_hp, 66);
    // player move 3: 300-16=284 saturates to 255
    load_move(2'd3);
    do_calc(1'b0, 2'd0, 255);
    target = 1'b1;
    apply_damage = 1'b1;
    tick();
    chk("ai_hp_floor", ai_hp, 0);
    chk("ai_zero_flag", ai_hp_zero, 1);
    chk("p_zero_flag", p_hp_zero, 0);
    apply_damage = 1'b0;
    tick();
    apply_damage = 1'b1;
    tick();
    chk("ai_hp_stays0", ai_hp, 0);
    chk("ai_zero_stays", ai_hp_zero, 1);
    apply_damage = 1'b0;
    tick();
    // move 0: main 40*40>>4=100-16=84; u_min 40*4>>4=10 <= 16 -> 1
    load_move(2'd0);
    do_calc(1'b0, 2'd0, 84);
    chk("min_dmg_move0", m_damage, 1);
    // calc dropped during MULT: single-cycle pulse still at the usual cycle
    calc_damage = 1'b1;
    tick();
    n = 0;
    while (!dmg_valid && n < 20) begin
      if (n == 3) calc_damage = 1'b0;
      tick();
      n++;
    end
    chk("drop_latency", n, 9);
    chk("drop_damage", damage, 84);
    tick();
    chk("drop_pulse", dmg_valid, 0);
    // reset in the middle of MULT
    calc_damage = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    calc_damage = 1'b0;
    tick();
    reset = 1'b0;
    chk("mid_rst_dv", dmg_valid, 0);
    chk("mid_rst_p_hp", p_hp, 200);
    chk("mid_rst_ai_hp", ai_hp, 200);
    chk("mid_rst_az", ai_hp_zero, 0);
    chk("mid_rst_damage", damage, 0);
    repeat (12) tick();
    chk("mid_rst_idle", dmg_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
